// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_reg
//  Purpose  : ID/EX pipeline register for the RV32 core. Captures the
//             hazard-muxed control bundle and the decode-stage operands and
//             presents them to EX one cycle later. Supports stall (hold),
//             flush (bubble insert) and a per-entry valid bit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: ID_EX_PERF_CNT_EN
//    defined   -> saturating bubble / stall performance counters
//    undefined -> bubble_cnt_o / stall_cnt_o tied to 0, no counter flops
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_i          clock, synchronous active-high reset
//    stall_i               hold current contents
//    flush_i               replace the entry with a bubble (beats stall_i)
//    valid_i               ID holds a real instruction
//    RegDst_i..MemWrite_i  control bundle from decode / hazard mux
//    pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, funct_i
//                          decode-stage data fields
//    *_o                   registered copies of the above, plus valid_o
//    bubble_cnt_o          bubbles inserted (optional)
//    stall_cnt_o           stall cycles (optional)
// ============================================================================
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] RegDst_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [3:0]        funct_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] RegDst_o,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [3:0]        funct_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // ------------------------------------------------------------------
    // Entry registers
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [REG_AW-1:0] r_reg_dst;
    logic [1:0]        r_alu_op;
    logic              r_alu_src;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [3:0]        r_funct;

    // A load with valid_i=0 becomes a bubble: control zeroed, data kept.
    // Writes to x0 are dropped here so EX/MEM/WB never see them.
    logic w_reg_write_q;
    assign w_reg_write_q = valid_i & RegWrite_i & (RegDst_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_valid      <= 1'b0;
            r_reg_dst    <= '0;
            r_alu_op     <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1_addr   <= '0;
            r_rs2_addr   <= '0;
            r_funct      <= '0;
        end else if (!stall_i) begin
            r_valid      <= valid_i;
            r_reg_dst    <= valid_i ? RegDst_i : '0;
            r_alu_op     <= valid_i ? ALUOp_i  : 2'b00;
            r_alu_src    <= valid_i & ALUSrc_i;
            r_reg_write  <= w_reg_write_q;
            r_mem_to_reg <= valid_i & MemToReg_i;
            // Illegal read+write combinations pass through untouched.
            r_mem_read   <= valid_i & MemRead_i;
            r_mem_write  <= valid_i & MemWrite_i;
            r_pc         <= pc_i;
            r_rs1_data   <= rs1_data_i;
            r_rs2_data   <= rs2_data_i;
            r_imm        <= imm_i;
            r_rs1_addr   <= rs1_addr_i;
            r_rs2_addr   <= rs2_addr_i;
            r_funct      <= funct_i;
        end
    end

    assign valid_o    = r_valid;
    assign RegDst_o   = r_reg_dst;
    assign ALUOp_o    = r_alu_op;
    assign ALUSrc_o   = r_alu_src;
    assign RegWrite_o = r_reg_write;
    assign MemToReg_o = r_mem_to_reg;
    assign MemRead_o  = r_mem_read;
    assign MemWrite_o = r_mem_write;
    assign pc_o       = r_pc;
    assign rs1_data_o = r_rs1_data;
    assign rs2_data_o = r_rs2_data;
    assign imm_o      = r_imm;
    assign rs1_addr_o = r_rs1_addr;
    assign rs2_addr_o = r_rs2_addr;
    assign funct_o    = r_funct;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_bubble_evt;
    logic             w_stall_evt;

    // A bubble is written on a flush, or on a load of an invalid slot.
    assign w_bubble_evt = flush_i | (~stall_i & ~valid_i);
    assign w_stall_evt  = stall_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble_evt && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
    assign stall_cnt_o  = r_stall_cnt;
`else
    assign bubble_cnt_o = '0;
    assign stall_cnt_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe_reg
//  Purpose  : Self-checking bench for id_ex_pipe_reg. Directed steps from the
//             test plan followed by randomized traffic, all compared against
//             a behavioural model of the pipeline entry and counters.
//             Counter expectations follow ID_EX_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_i, stall_i, flush_i, valid_i;
    logic [REG_AW-1:0] RegDst_i;
    logic [1:0]        ALUOp_i;
    logic              ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
    logic [XLEN-1:0]   pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [REG_AW-1:0] rs1_addr_i, rs2_addr_i;
    logic [3:0]        funct_i;
    logic              valid_o;
    logic [REG_AW-1:0] RegDst_o;
    logic [1:0]        ALUOp_o;
    logic              ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o;
    logic [XLEN-1:0]   pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [REG_AW-1:0] rs1_addr_o, rs2_addr_o;
    logic [3:0]        funct_o;
    logic [CNT_W-1:0]  bubble_cnt_o, stall_cnt_o;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
        .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .funct_i(funct_i),
        .valid_o(valid_o), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o),
        .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .pc_o(pc_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .funct_o(funct_o),
        .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    // ------------------------------------------------------------------
    // Reference model: what EX should hold, as a plain record
    // ------------------------------------------------------------------
    typedef struct {
        int valid, rd, aluop, alusrc, regwrite, memtoreg, memread, memwrite;
        int pc, rs1d, rs2d, imm, rs1a, rs2a, funct;
    } entry_t;

    entry_t m;
    int     m_bubbles;
    int     m_stalls;
    int     checks = 0;
    int     errors = 0;
    int     cnt_max;

    function automatic entry_t empty_entry();
        entry_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Apply the rules for one rising edge to the model, using current inputs.
    task automatic model_edge();
        entry_t e;
        bit bubble_written;
        bubble_written = 1'b0;
        if (rst_i) begin
            m = empty_entry();
            m_bubbles = 0;
            m_stalls  = 0;
        end else if (flush_i) begin
            m = empty_entry();
            bubble_written = 1'b1;
        end else if (stall_i) begin
            m_stalls = (m_stalls < cnt_max) ? m_stalls + 1 : cnt_max;
        end else begin
            e = empty_entry();
            e.pc = int'(pc_i);   e.rs1d = int'(rs1_data_i);
            e.rs2d = int'(rs2_data_i); e.imm = int'(imm_i);
            e.rs1a = int'(rs1_addr_i); e.rs2a = int'(rs2_addr_i);
            e.funct = int'(funct_i);
            if (valid_i) begin
                e.valid    = 1;
                e.rd       = int'(RegDst_i);
                e.aluop    = int'(ALUOp_i);
                e.alusrc   = int'(ALUSrc_i);
                e.regwrite = (RegDst_i == 0) ? 0 : int'(RegWrite_i);
                e.memtoreg = int'(MemToReg_i);
                e.memread  = int'(MemRead_i);
                e.memwrite = int'(MemWrite_i);
            end else begin
                bubble_written = 1'b1;
            end
            m = e;
        end
        if (bubble_written)
            m_bubbles = (m_bubbles < cnt_max) ? m_bubbles + 1 : cnt_max;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        int eb, es;
`ifdef ID_EX_PERF_CNT_EN
        eb = m_bubbles; es = m_stalls;
`else
        eb = 0; es = 0;
`endif
        chk({step, ".valid"},    32'(valid_o),    32'(m.valid));
        chk({step, ".rd"},       32'(RegDst_o),   32'(m.rd));
        chk({step, ".aluop"},    32'(ALUOp_o),    32'(m.aluop));
        chk({step, ".alusrc"},   32'(ALUSrc_o),   32'(m.alusrc));
        chk({step, ".regwrite"}, 32'(RegWrite_o), 32'(m.regwrite));
        chk({step, ".memtoreg"}, 32'(MemToReg_o), 32'(m.memtoreg));
        chk({step, ".memread"},  32'(MemRead_o),  32'(m.memread));
        chk({step, ".memwrite"}, 32'(MemWrite_o), 32'(m.memwrite));
        chk({step, ".pc"},       pc_o,            32'(m.pc));
        chk({step, ".rs1d"},     rs1_data_o,      32'(m.rs1d));
        chk({step, ".rs2d"},     rs2_data_o,      32'(m.rs2d));
        chk({step, ".imm"},      imm_o,           32'(m.imm));
        chk({step, ".rs1a"},     32'(rs1_addr_o), 32'(m.rs1a));
        chk({step, ".rs2a"},     32'(rs2_addr_o), 32'(m.rs2a));
        chk({step, ".funct"},    32'(funct_o),    32'(m.funct));
        chk({step, ".bubcnt"},   32'(bubble_cnt_o), 32'(eb));
        chk({step, ".stlcnt"},   32'(stall_cnt_o),  32'(es));
    endtask

    // One clock: edge, model update, then sample 1 time unit later.
    task automatic tick(input string step);
        @(posedge clk);
        model_edge();
        #1;
        check_all(step);
    endtask

    task automatic rand_payload();
        logic [31:0] r;
        r = $urandom; RegDst_i = (r[31:30] == 2'b00) ? '0 : r[4:0];
        ALUOp_i = r[6:5]; ALUSrc_i = r[7]; RegWrite_i = r[8];
        MemToReg_i = r[9]; MemRead_i = r[10]; MemWrite_i = r[11];
        rs1_addr_i = r[16:12]; rs2_addr_i = r[21:17]; funct_i = r[25:22];
        pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
        valid_i = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        logic [31:0] r;
        cnt_max = (1 << CNT_W) - 1;
        m = empty_entry();
        m_bubbles = 0;
        m_stalls  = 0;

        // Reset with all inputs nonzero
        rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1;
        RegDst_i = 5'd31; ALUOp_i = 2'b11; ALUSrc_i = 1'b1; RegWrite_i = 1'b1;
        MemToReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b1;
        pc_i = 32'hFFFF_FFFF; rs1_data_i = 32'h1234_5678; rs2_data_i = 32'h8765_4321;
        imm_i = 32'hA5A5_A5A5; rs1_addr_i = 5'd7; rs2_addr_i = 5'd9; funct_i = 4'hF;
        tick("reset0");
        tick("reset1");
        chk("reset.valid_lit", 32'(valid_o), 32'd0);

        // Directed load
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        rand_payload();
        valid_i = 1'b1; RegDst_i = 5'd5; ALUOp_i = 2'b10; RegWrite_i = 1'b1;
        pc_i = 32'h100; rs1_data_i = 32'hDEAD_BEEF;
        tick("load");
        chk("load.pc_lit", pc_o, 32'h100);
        chk("load.rs1d_lit", rs1_data_o, 32'hDEAD_BEEF);
        chk("load.regwrite_lit", 32'(RegWrite_o), 32'd1);

        // Stall three cycles while the next PC waits
        stall_i = 1'b1; pc_i = 32'h104;
        tick("stall0");
        tick("stall1");
        tick("stall2");
        chk("stall.pc_lit", pc_o, 32'h100);
        chk("stall.valid_lit", 32'(valid_o), 32'd1);
        stall_i = 1'b0;
        tick("stall_release");
        chk("release.pc_lit", pc_o, 32'h104);

        // Flush beats a simultaneous stall
        flush_i = 1'b1; stall_i = 1'b1; MemWrite_i = 1'b1; valid_i = 1'b1;
        tick("flush_stall");
        chk("flush.memwrite_lit", 32'(MemWrite_o), 32'd0);
        chk("flush.pc_lit", pc_o, 32'h0);

        // x0 write suppression
        flush_i = 1'b0; stall_i = 1'b0;
        valid_i = 1'b1; RegWrite_i = 1'b1; RegDst_i = '0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        tick("x0");
        chk("x0.regwrite_lit", 32'(RegWrite_o), 32'd0);
        chk("x0.memread_lit", 32'(MemRead_o), 32'd1);

        // Invalid slot loads as a bubble with data still captured
        valid_i = 1'b0; RegDst_i = 5'd12; RegWrite_i = 1'b1; pc_i = 32'h200; imm_i = 32'h55;
        tick("bubble_load");
        chk("bubble.pc_lit", pc_o, 32'h200);

        // Illegal read+write passes through
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b1;
        tick("rw_both");

        // Counter saturation and clear
        rst_i = 1'b1; tick("cnt_rst0");
        rst_i = 1'b0; flush_i = 1'b1;
        for (int i = 0; i < 5; i++) tick("flush_run");
        flush_i = 1'b0; stall_i = 1'b1;
        for (int i = 0; i < 2; i++) tick("stall_run");
        stall_i = 1'b0; rst_i = 1'b1;
        tick("cnt_rst1");

        // Randomized traffic, including reset mid-stall/mid-flush
        rst_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_payload();
            r = $urandom;
            stall_i = (r[2:0] == 3'd0) || (r[2:0] == 3'd1);
            flush_i = (r[5:3] == 3'd0);
            rst_i   = (r[10:6] == 5'd0);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
